// File: rtl/bus_combine_pipe.sv
// bus_combine_pipe
//   Combines two operand buses (AND / OR / XOR / ADD, chosen per beat by
//   mode) and carries the result through a DEPTH-stage elastic pipeline.
//   The pipeline uses valid/ready handshakes. It inserts no bubbles, and
//   empty slots collapse when downstream stalls.
//
//   Optional feature: define BUS_COMBINE_PIPE_PARITY_EN to add the out_par
//   port. The even parity of the result is computed at acceptance and
//   travels with the beat.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset; empties the pipeline and
//              clears all data
//   in0, in1   operands (WIDTH bits)
//   mode       00 AND, 01 OR, 10 XOR, 11 ADD; sampled with the beat
//   in_valid   upstream beat present
//   in_ready   beat accepted this cycle when in_valid is also high
//   out        result of the oldest beat (WIDTH bits)
//   out_carry  carry-out of an ADD beat; 0 for the other modes
//   out_valid  out / out_carry hold a valid beat
//   out_ready  downstream consumes the beat
//   out_par    even parity of out (only with BUS_COMBINE_PIPE_PARITY_EN)
module bus_combine_pipe #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_carry,
  output logic             out_valid,
  input  logic             out_ready
`ifdef BUS_COMBINE_PIPE_PARITY_EN
  ,
  output logic             out_par
`endif
);

  // Beat payload layout: {[parity,] carry, result}
`ifdef BUS_COMBINE_PIPE_PARITY_EN
  localparam int PW = WIDTH + 2;
`else
  localparam int PW = WIDTH + 1;
`endif

  typedef logic [PW-1:0] pay_t;

  function automatic logic [WIDTH:0] combine(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [1:0]       m);
    logic [WIDTH:0] r;
    case (m)
      2'b00:   r = {1'b0, a & b};
      2'b01:   r = {1'b0, a | b};
      2'b10:   r = {1'b0, a ^ b};
      default: r = {1'b0, a} + {1'b0, b};
    endcase
    return r;
  endfunction

`ifdef BUS_COMBINE_PIPE_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction
`endif

  logic [DEPTH-1:0] vld_q, vld_d;
  pay_t             pay_q [DEPTH];
  pay_t             pay_d [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [WIDTH:0]   res;
  pay_t             new_pay;

  // Input side: result formed combinationally at acceptance
  always_comb begin
    res = combine(in0, in1, mode);
`ifdef BUS_COMBINE_PIPE_PARITY_EN
    new_pay = {even_parity(res[WIDTH-1:0]), res};
`else
    new_pay = res;
`endif
  end

  // Advance chain, walked from the output back to stage 0.
  // 'room' means the stage downstream of k can take a beat this cycle:
  // either it is empty or it advances itself.
  // This makes out_ready -> in_ready a purely combinational path.
  always_comb begin
    logic room;
    room = out_ready;
    adv  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k] = vld_q[k] & room;
      room   = ~vld_q[k] | room;
    end
    in_ready = room;
  end

  always_comb begin
    vld_d = vld_q;
    pay_d = pay_q;
    // stage 0 loads from the input
    if (in_valid && in_ready) begin
      vld_d[0] = 1'b1;
      pay_d[0] = new_pay;
    end else if (adv[0]) begin
      vld_d[0] = 1'b0;
    end
    // stages 1..DEPTH-1 load unmodified from the stage behind them
    for (int k = 1; k < DEPTH; k++) begin
      if (adv[k-1]) begin
        vld_d[k] = 1'b1;
        pay_d[k] = pay_q[k-1];
      end else if (adv[k]) begin
        vld_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      pay_q <= '{default: '0};
    end else begin
      vld_q <= vld_d;
      pay_q <= pay_d;
    end
  end

  // Output side: driven straight from the last stage registers
  assign out       = pay_q[DEPTH-1][WIDTH-1:0];
  assign out_carry = pay_q[DEPTH-1][WIDTH];
  assign out_valid = vld_q[DEPTH-1];
`ifdef BUS_COMBINE_PIPE_PARITY_EN
  assign out_par   = pay_q[DEPTH-1][WIDTH+1];
`endif

endmodule

// File: tb/tb_bus_combine_pipe.sv
// Testbench for bus_combine_pipe.
//
// Main instance: WIDTH=8, DEPTH=3.
//   Checked every cycle against a transaction-level model.
//   The model keeps a FIFO of expected results, each tagged with its
//   acceptance cycle:
//     - occupancy decides in_ready (blocked only when full and out_ready=0);
//     - the head beat is visible at max(accept + DEPTH, previous delivery + 1).
//
// Second instance: WIDTH=2, DEPTH=2, for the first-beat latency case.
module tb_bus_combine_pipe;
  localparam int W = 8;
  localparam int D = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [W-1:0] in0, in1, out;
  logic [1:0]   mode;
  logic         in_valid, in_ready, out_carry, out_valid, out_ready;

  logic [1:0]   d2_in0, d2_in1, d2_out, d2_mode;
  logic         d2_in_valid, d2_in_ready, d2_out_carry, d2_out_valid, d2_out_ready;

`ifdef BUS_COMBINE_PIPE_PARITY_EN
  logic out_par, d2_out_par;
`endif

  bus_combine_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in0(in0), .in1(in1), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .out(out),
    .out_carry(out_carry), .out_valid(out_valid), .out_ready(out_ready)
`ifdef BUS_COMBINE_PIPE_PARITY_EN
    , .out_par(out_par)
`endif
  );

  bus_combine_pipe #(.WIDTH(2), .DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in0(d2_in0), .in1(d2_in1), .mode(d2_mode),
    .in_valid(d2_in_valid), .in_ready(d2_in_ready), .out(d2_out),
    .out_carry(d2_out_carry), .out_valid(d2_out_valid), .out_ready(d2_out_ready)
`ifdef BUS_COMBINE_PIPE_PARITY_EN
    , .out_par(d2_out_par)
`endif
  );

  typedef struct {
    logic [W-1:0] res;
    logic         carry;
    int           acc_cyc;
  } beat_t;

  beat_t q[$];
  int    cyc, last_del, vectors, miscompares, n_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t model_beat(input logic [1:0] m, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input int c);
    beat_t r;
    int    s;
    r.carry   = 1'b0;
    r.acc_cyc = c;
    case (m)
      2'd0: r.res = a & b;
      2'd1: r.res = a | b;
      2'd2: r.res = a ^ b;
      default: begin
        s       = int'(a) + int'(b);
        r.res   = s[W-1:0];
        r.carry = (s >= (1 << W));
      end
    endcase
    return r;
  endfunction

  // One clock cycle on the main instance.
  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input logic v, input logic [1:0] m, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic r);
    logic  exp_rdy, exp_vld, acc, del;
    int    avail;
    beat_t nb, gone;
    in_valid = v; mode = m; in0 = a; in1 = b; out_ready = r;
    #1;
    exp_rdy = r || (q.size() < D);
    check("in_ready", in_ready, exp_rdy);
    exp_vld = 1'b0;
    if (q.size() > 0) begin
      avail   = (q[0].acc_cyc + D > last_del + 1) ? q[0].acc_cyc + D : last_del + 1;
      exp_vld = (cyc >= avail);
    end
    check("out_valid", out_valid, exp_vld);
    if (exp_vld) begin
      check("out", out, q[0].res);
      check("out_carry", out_carry, q[0].carry);
`ifdef BUS_COMBINE_PIPE_PARITY_EN
      check("out_par", out_par, ^q[0].res);
`endif
    end
    acc = v && exp_rdy;
    del = exp_vld && r;
    nb  = model_beat(m, a, b, cyc);
    @(posedge clk);
    #1;
    if (del) begin
      gone     = q.pop_front();
      last_del = cyc;
    end
    if (acc) begin
      q.push_back(nb);
      n_acc++;
    end
    cyc++;
  endtask

  task automatic rand_step(input int pv, input int pr);
    step(($urandom_range(0, 99) < pv), 2'($urandom_range(0, 3)),
         W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
         ($urandom_range(0, 99) < pr));
  endtask

  // Asynchronous reset pulse placed mid-cycle
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_out_carry", out_carry, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_d2_out_valid", d2_out_valid, 0);
    check("rst_d2_in_ready", d2_in_ready, 1);
`ifdef BUS_COMBINE_PIPE_PARITY_EN
    check("rst_out_par", out_par, 0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    cyc = 0;
    last_del = -10;
  endtask

  initial begin
    vectors = 0; miscompares = 0; n_acc = 0;
    cyc = 0; last_del = -10;
    rst_n = 1'b0;
    in_valid = 0; in0 = '0; in1 = '0; mode = '0; out_ready = 0;
    d2_in_valid = 0; d2_in0 = '0; d2_in1 = '0; d2_mode = '0; d2_out_ready = 0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out", out, 0);
    check("reset_out_carry", out_carry, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_d2_out", d2_out, 0);
    rst_n = 1'b1;

    // first-beat latency: WIDTH=2, DEPTH=2, AND of 10 and 11
    d2_out_ready = 1; d2_in_valid = 1; d2_in0 = 2'b10; d2_in1 = 2'b11; d2_mode = 2'b00;
    #1;
    check("d2_in_ready_c0", d2_in_ready, 1);
    check("d2_out_valid_c0", d2_out_valid, 0);
    @(posedge clk); #1;
    d2_in_valid = 0;
    check("d2_out_valid_c1", d2_out_valid, 0);
    @(posedge clk); #1;
    check("d2_out_valid_c2", d2_out_valid, 1);
    check("d2_out_c2", d2_out, 2'b10);
    check("d2_carry_c2", d2_out_carry, 0);
    @(posedge clk); #1;
    check("d2_out_valid_c3", d2_out_valid, 0);

    // ADD with carry, then XOR of the same operands
    step(1, 2'b11, 8'hF0, 8'h20, 1);
    step(1, 2'b10, 8'hF0, 8'h20, 1);
    step(0, 2'b00, 8'h00, 8'h00, 1);
    check("add_out", out, 8'h10);
    check("add_carry", out_carry, 1);
    check("add_valid", out_valid, 1);
    step(0, 2'b00, 8'h00, 8'h00, 1);
    check("xor_out", out, 8'hD0);
    check("xor_carry", out_carry, 0);
    check("xor_valid", out_valid, 1);
    repeat (3) step(0, 2'b00, 8'h00, 8'h00, 1);

    // fill while stalled: only DEPTH beats fit, then drain back-to-back
    pulse_reset();
    n_acc = 0;
    for (int i = 0; i < 5; i++)
      step(1, 2'($urandom_range(0, 3)), W'(8'h11 * i), W'(8'h07 + i), 0);
    check("stall_accepted", n_acc, 3);
    for (int i = 0; i < 2; i++)
      step(1, 2'($urandom_range(0, 3)), W'(8'h11 * (i + 3)), W'(8'h07 + i + 3), 1);
    repeat (6) step(0, 2'b00, 8'h00, 8'h00, 1);
    check("stall_total_accepted", n_acc, 5);

    // random traffic
    for (int i = 0; i < 400; i++) rand_step(70, 60);

    // full pipe with continuous flow
    for (int i = 0; i < 30; i++) rand_step(100, 100);

    // bubbles collapsing under heavy back-pressure
    for (int i = 0; i < 80; i++) rand_step(50, 30);

    // reset with two beats in flight
    pulse_reset();
    step(1, 2'b11, 8'h81, 8'h90, 0);
    step(1, 2'b01, 8'h0F, 8'h30, 0);
    pulse_reset();
    for (int i = 0; i < 5; i++) step(0, 2'b00, 8'h00, 8'h00, 1);

    // traffic resumes normally after that reset
    for (int i = 0; i < 60; i++) rand_step(70, 70);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_combine_pipe.md
BUS_COMBINE_PIPE -- requirements
Module: bus_combine_pipe

Interface
REQ-001 Parameter WIDTH, default 2, data width of in0, in1, out; legal 1..32.
REQ-002 Parameter DEPTH, default 2, number of pipeline register stages; legal 1..8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in0  input  WIDTH  operand A.
REQ-006 in1  input  WIDTH  operand B.
REQ-007 mode  input  2  operation, sampled with the beat: 00 AND, 01 OR, 10 XOR, 11 ADD.
REQ-008 in_valid  input  1  upstream beat present.
REQ-009 in_ready  output  1  block accepts beat this cycle.
REQ-010 out  output  WIDTH  result of oldest beat.
REQ-011 out_carry  output  1  carry of ADD beat; 0 for other modes.
REQ-012 out_valid  output  1  out/out_carry hold a valid beat.
REQ-013 out_ready  input  1  downstream consumes beat.
REQ-014 out_par  output  1  even parity of out; present only when macro of REQ-029 is defined.

Function
REQ-015 Beat accepted on a cycle with in_valid=1 and in_ready=1; beat delivered on a cycle with out_valid=1 and out_ready=1.
REQ-016 Result computed combinationally from in0/in1/mode at acceptance and captured into stage 0; stages 1..DEPTH-1 carry it unmodified; out/out_carry/out_valid driven directly from stage DEPTH-1 registers.
REQ-017 ADD: {out_carry,out} = in0 + in1 at WIDTH+1 bits; out wraps modulo 2^WIDTH.
REQ-018 Stage k loads from stage k-1 (or input, k=0) when stage k is empty or stage k advances this cycle; stage k empties when it advances and nothing loads.
REQ-019 in_ready = !valid(stage0) || stage0 advances; path from out_ready to in_ready is combinational; no bubbles inserted.
REQ-020 Latency with out_ready held 1: beat accepted in cycle N has out_valid=1 in cycle N+DEPTH; throughput one beat per cycle.
REQ-021 Capacity DEPTH beats; when all stages valid and out_ready=0, in_ready=0 and all stage contents frozen.
REQ-022 Full with out_ready=1 and in_valid=1 same cycle: one beat delivered and one accepted; occupancy unchanged.
REQ-023 Beats delivered strictly in acceptance order; none dropped or duplicated outside reset.
REQ-024 out and out_carry stable while out_valid=1 and out_ready=0.
REQ-025 in_valid=0 cycles create empty slots that collapse when downstream stalls (stage fills behind empty stage).

Reset
REQ-026 rst_n low asynchronously clears all stage valid bits and data registers: out_valid=0, out=0, out_carry=0, out_par=0.
REQ-027 During and immediately after reset in_ready=1 (pipeline empty); first acceptance on first rising edge with rst_n high.
REQ-028 Reset mid-operation discards all in-flight beats; no beat delivered from pre-reset state.

Configuration
REQ-029 Macro BUS_COMBINE_PIPE_PARITY_EN defined: out_par port exists, parity computed at acceptance and piped with the beat, obeys REQ-024; undefined: port and its register absent, all other behaviour identical.

Verification
REQ-030 WIDTH=2, DEPTH=2, out_ready=1; accept in0=2'b10,in1=2'b11,mode=00 cycle 0 -> out=2'b10, out_valid=1 at cycle 2 only.
REQ-031 WIDTH=8, mode=11, in0=8'hF0, in1=8'h20 -> out=8'h10, out_carry=1; then mode=10 same operands -> out=8'hD0, out_carry=0.
REQ-032 DEPTH=3, out_ready=0, in_valid=1 for 5 cycles -> exactly 3 accepted, in_ready=0 from cycle 3; raise out_ready -> 3 beats in order, then remaining 2, back-to-back.
REQ-033 Full pipeline, out_ready=1 and in_valid=1 held -> in_ready=1 every cycle, one delivery per cycle, no gaps.
REQ-034 Two beats in flight, rst_n pulsed low mid-cycle -> out_valid=0 and out=0 immediately, no later delivery of those beats, in_ready=1.
REQ-035 Macro defined, WIDTH=4, out=4'b1011 -> out_par=1; out=4'b0110 -> out_par=0; macro undefined -> build without out_par, REQ-030..034 pass unchanged.
